// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
// The optional sync_in alignment input is enabled by defining CLK_DIV_MULTI_SYNC_EN.
package clk_div_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 16;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clk_mode_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, active/pending divisor+mode, tick and clk_out.
// With CLK_DIV_MULTI_SYNC_EN defined, a sync input realigns the channel phase.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int             DIV_W   = DEF_DIV_W,
  parameter logic [DIV_W-1:0] RST_DIV = '0
)(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  clk_mode_e        mode_act;
  clk_mode_e        mode_pend;
  logic             wrap;
  logic             realign;

  assign wrap = (cnt == div_act);

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign realign = !en || sync;
`else
  assign realign = !en;
`endif

  // A pending update lands on a realign or on a wrap seen while busy; the wrap
  // itself is still decided and shaped by the old divisor/mode. A write in the
  // same cycle reloads pending after the old pending has been consumed.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      clk_out   <= 1'b1;
      tick      <= 1'b0;
      busy      <= 1'b0;
      div_act   <= RST_DIV;
      mode_act  <= MODE_TOGGLE;
      div_pend  <= '0;
      mode_pend <= MODE_TOGGLE;
    end else begin
      if (realign) begin
        cnt     <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b0;
        busy    <= 1'b0;
        if (busy) begin
          div_act  <= div_pend;
          mode_act <= mode_pend;
        end
      end else begin
        tick <= wrap;
        if (wrap) begin
          cnt     <= '0;
          clk_out <= (mode_act == MODE_TOGGLE) ? ~clk_out : 1'b1;
          busy    <= 1'b0;
          if (busy) begin
            div_act  <= div_pend;
            mode_act <= mode_pend;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (mode_act == MODE_PULSE) clk_out <= 1'b0;
        end
      end

      if (wr_en) begin
        if (en) begin
          div_pend  <= wr_div;
          mode_pend <= clk_mode_e'(wr_mode);
          busy      <= 1'b1;
        end else begin
          div_act  <= wr_div;
          mode_act <= clk_mode_e'(wr_mode);
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one write port.
// Defining CLK_DIV_MULTI_SYNC_EN adds sync_in, which realigns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  DIV_W   = DEF_DIV_W,
  parameter int  RST_DIV = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              clk_in,
  input  logic              rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              wr_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  // Write port: wr_en is a single-cycle qualifier with no ready; every strobe
  // is taken on that clk_in edge, and a wr_ch with no matching channel is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_en && (wr_ch == CH_W'(i));

    clk_div_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV (DIV_W'(RST_DIV))
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[i]),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync    (sync_in),
`endif
      .wr_en   (sel),
      .wr_div  (wr_div),
      .wr_mode (wr_mode),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, meaning divisor and counter width.
REQ-003 SHALL have parameter RST_DIV, default 0, meaning active divisor of every channel after reset.
REQ-004 SHALL have port clk_in, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port ch_en, input, NUM_CH, per-channel run enable.
REQ-007 SHALL have port wr_en, input, 1, one-cycle divisor/mode write strobe.
REQ-008 SHALL have port wr_ch, input, CH_W = max(1, clog2(NUM_CH)), target channel.
REQ-009 SHALL have port wr_div, input, DIV_W, new divisor.
REQ-010 SHALL have port wr_mode, input, 1, new mode (0 toggle, 1 pulse).
REQ-011 SHALL have port clk_out, output, NUM_CH, per-channel divided output.
REQ-012 SHALL have port tick, output, NUM_CH, one-cycle strobe per channel wrap.
REQ-013 SHALL have port busy, output, NUM_CH, high while a written update is pending.

Function
REQ-014 Enabled channel: cnt==div_act -> cnt<=0 (wrap); else cnt<=cnt+1.
REQ-015 At wrap, tick SHALL be high for exactly the following cycle (registered).
REQ-016 Toggle mode: clk_out toggles at each wrap; period 2*(div_act+1) cycles, 50% duty.
REQ-017 Pulse mode: clk_out equals tick; period div_act+1 cycles; div_act=0 gives tick constantly high.
REQ-018 Toggle mode with div_act=0 SHALL produce clk_in/2.
REQ-019 wr_en with wr_ch>=NUM_CH SHALL be ignored with no state change.
REQ-020 Write to an enabled channel SHALL load pending div/mode and set busy the next cycle.
REQ-021 Pending values SHALL become active at the first wrap after busy is high; that wrap uses old values; busy clears the same edge.
REQ-022 Write in the same cycle as a wrap SHALL apply at the following wrap, not the current one.
REQ-023 Write while busy SHALL overwrite pending values; only the last write applies.
REQ-024 Write to a disabled channel SHALL become active the next cycle; busy stays low.
REQ-025 Mode change pulse->toggle applied at wrap SHALL set clk_out to 1 instead of toggling.
REQ-026 ch_en low SHALL, next cycle, force cnt=0, clk_out=1, tick=0 and apply any pending update.
REQ-027 Re-enable SHALL count from 0; first toggle/tick after div_act+1 enabled cycles.
REQ-028 Channels SHALL be fully independent; simultaneous wraps on all channels are legal.
REQ-029 Divisor arithmetic SHALL be unsigned DIV_W-bit; cnt never exceeds div_act.

Reset
REQ-030 rst high SHALL asynchronously set per channel: cnt=0, clk_out=1, tick=0, busy=0, div_act=RST_DIV, mode=toggle, pending cleared.
REQ-031 rst mid-period or with pending update SHALL discard the update; counting restarts on first edge after deassertion.

Configuration
REQ-032 Macro CLK_DIV_MULTI_SYNC_EN defined SHALL add input sync_in (1 bit).
REQ-033 With macro: sync_in high for one cycle SHALL, next cycle, set all enabled channels to cnt=0, clk_out=1, tick=0, apply pending, clear busy; sync overrides wrap.
REQ-034 Without macro: sync_in port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-035 Package clk_div_pkg SHALL hold enum clk_mode_e {MODE_TOGGLE, MODE_PULSE} and default constants for DIV_W and NUM_CH.
REQ-036 One sub-module clk_div_ch SHALL implement a single channel (counter, active/pending registers, outputs), instantiated NUM_CH times by generate.

Verification
REQ-037 Reset, ch_en[0]=1, write div=3 toggle -> clk_out[0] period 8 cycles, 4 high / 4 low, tick every 4 cycles.
REQ-038 Pulse mode div=4 on ch1 -> tick[1] and clk_out[1] high 1 cycle every 5; div=0 -> constantly high.
REQ-039 Running ch0 div=9; write div=2 mid-period -> busy=1, current period completes with 10 counts, then 3-count half-periods, busy clears at that wrap.
REQ-040 Two writes (div=5, then 7) while busy -> only 7 applied; write with wr_ch=NUM_CH -> no change.
REQ-041 Drop ch_en mid-count -> clk_out=1, tick=0 next cycle; re-enable -> first toggle after div+1 cycles.
REQ-042 Assert rst asynchronously mid-period with pending update -> outputs reset immediately, div_act=RST_DIV; with CLK_DIV_MULTI_SYNC_EN, sync_in pulse aligns all channels' phases.
